// File: rtl/buffer_rr_arbiter.sv
// Round-robin arbiter feeding a single registered output stage.
// N requesters compete for one WIDTH-bit buffer register. The winner is picked
// by rotating priority starting after the last captured source. The buffered
// word is offered downstream with a valid/ready handshake.
module buffer_rr_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned SRC_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] data,
    output logic [N-1:0]       gnt,
    output logic [WIDTH-1:0]   out_data,
    output logic [SRC_W-1:0]   out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } state_e;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   last_q, last_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [WIDTH-1:0]   data_q, data_d;

    logic               can_load;
    logic               found;
    logic               load;
    logic [SRC_W-1:0]   winner;
    int unsigned        arb_idx;

    // Output register may take a new word when empty or being drained this cycle.
    always_comb begin
        can_load = (state_q == StEmpty) || out_ready;
    end

    // Rotating-priority search: last+1, last+2, ... wrapping modulo N.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        arb_idx = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            arb_idx = (32'(last_q) + off) % N;
            if (!found && req[arb_idx]) begin
                found  = 1'b1;
                winner = SRC_W'(arb_idx);
            end
        end
    end

    // Grant is one-hot on the winner, suppressed during reset or back-pressure.
    always_comb begin
        gnt = '0;
        if (!rst && can_load && found) begin
            gnt[winner] = 1'b1;
        end
        load = |gnt;
    end

    // Next-state and datapath: capture on grant, drain when accepted without reload.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        src_d   = src_q;
        data_d  = data_q;
        if (load) begin
            state_d = StFull;
            last_d  = winner;
            src_d   = winner;
            data_d  = data[32'(winner)*WIDTH +: WIDTH];
        end else if (state_q == StFull && out_ready) begin
            // Word leaves; data and source keep their last value.
            state_d = StEmpty;
        end
    end

    // State register with synchronous reset; pointer resets so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            last_q  <= SRC_W'(N - 1);
            src_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            src_q   <= src_d;
            data_q  <= data_d;
        end
    end

    // Drive outputs straight from the registers.
    always_comb begin
        out_valid = (state_q == StFull);
        out_data  = data_q;
        out_src   = src_q;
    end

    // Grant must never select more than one requester.
    always_ff @(posedge clk) begin
        assert ($onehot0(gnt));
    end

endmodule
